condlogic_pipe: RTL and testbench

Parametrised successor to the single-cycle conditional-execution logic used by the pipelined core. It holds `NBANK` independent NZCV flag banks and evaluates the 4-bit condition field against the bank chosen by the instruction. It gates register, memory and PC writes, and adds an IT-style predication state machine that overrides the condition of up to `ITMAX` following instructions. It sits in the execute stage between the ALU and the writeback/PC-select logic, and honours stall (`en`) and `flush`.

---
 rtl/condlogic_pipe.sv | 187 ++++++++++++++++++
 tb/tb_condlogic_pipe.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/condlogic_pipe.sv
// condlogic_pipe
//   Execute-stage conditional-execution unit. It holds NBANK independent
//   NZCV flag banks and evaluates the 4-bit condition field against the bank
//   named by bankSel. It gates the PC, register and memory write requests.
//   It also runs an IT-style predication FSM that overrides the condition of
//   up to ITMAX following instructions.
//
// Ports
//   clk, reset        : clock, synchronous active-high reset
//   en, flush         : instruction valid/advance (0 = stall); kill + IT abort
//   cond, bankSel     : instruction condition field and flag bank select
//   ALUFlags, flagW   : {N,Z,C,V} from the ALU; [1] writes N,Z, [0] writes C,V
//   PCS, regW, memW   : ungated write requests from decode
//   itStart, itCount,
//   itCond, itMask    : IT instruction, block length, base condition, then/else mask
//   condEx            : effective condition passed (combinational)
//   PCSrc, regWrite,
//   memWrite          : gated write requests
//   itActive          : IT block in progress
//   flagsOut          : registered flags of bank bankSel
module condlogic_pipe #(
  parameter int NBANK = 2,
  parameter int BW    = (NBANK > 1) ? $clog2(NBANK) : 1,
  parameter int ITMAX = 4,
  parameter int ITW   = $clog2(ITMAX + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             flush,
  input  logic [3:0]       cond,
  input  logic [BW-1:0]    bankSel,
  input  logic [3:0]       ALUFlags,
  input  logic [1:0]       flagW,
  input  logic             PCS,
  input  logic             regW,
  input  logic             memW,
  input  logic             itStart,
  input  logic [ITW-1:0]   itCount,
  input  logic [3:0]       itCond,
  input  logic [ITMAX-1:0] itMask,
  output logic             condEx,
  output logic             PCSrc,
  output logic             regWrite,
  output logic             memWrite,
  output logic             itActive,
  output logic [3:0]       flagsOut
);

  localparam int IDXW = (ITMAX > 1) ? $clog2(ITMAX) : 1;

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t           state, state_nxt;
  logic [ITW-1:0]   remain, remain_nxt;
  logic [IDXW-1:0]  idx, idx_nxt;
  logic [3:0]       itcondr, itcondr_nxt;
  logic [ITMAX-1:0] itmaskr, itmaskr_nxt;

  logic [3:0] bank [NBANK];
  logic       bank_ok;
  logic [3:0] flags_sel;
  logic [3:0] eff_cond;
  logic       active_v;
  logic       go;

  function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v, ge;
    n  = f[3];
    z  = f[2];
    cf = f[1];
    v  = f[0];
    ge = (n == v);
    case (c)
      4'b0000: cond_pass = z;
      4'b0001: cond_pass = ~z;
      4'b0010: cond_pass = cf;
      4'b0011: cond_pass = ~cf;
      4'b0100: cond_pass = n;
      4'b0101: cond_pass = ~n;
      4'b0110: cond_pass = v;
      4'b0111: cond_pass = ~v;
      4'b1000: cond_pass = cf & ~z;
      4'b1001: cond_pass = ~(cf & ~z);
      4'b1010: cond_pass = ge;
      4'b1011: cond_pass = ~ge;
      4'b1100: cond_pass = ~z & ge;
      4'b1101: cond_pass = ~(~z & ge);
      4'b1110: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  endfunction

  // Non-power-of-two bank counts leave unused select codes; they read as
  // zero flags and are never written.
  assign bank_ok = (int'(bankSel) < NBANK);

  always_comb begin
    flags_sel = '0;
    if (bank_ok) flags_sel = bank[bankSel];
  end

  assign flagsOut = flags_sel;

  // While reset is asserted the IT state may still be stale until the edge,
  // so the block is masked out here to keep outputs quiet and use own cond.
  assign active_v = (state == ACTIVE) & ~reset;
  assign itActive = active_v;

  always_comb begin
    eff_cond = cond;
    if (active_v) eff_cond = itmaskr[idx] ? itcondr : (itcondr ^ 4'b0001);
  end

  assign condEx   = cond_pass(eff_cond, flags_sel);
  assign go       = en & ~flush & condEx & ~reset;
  assign regWrite = regW & go;
  assign memWrite = memW & go;
  assign PCSrc    = PCS & go;

  // Flag banks: only the selected bank is written, in halves.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned b = 0; b < NBANK; b++) bank[b] <= '0;
    end else if (go && bank_ok) begin
      if (flagW[1]) bank[bankSel][3:2] <= ALUFlags[3:2];
      if (flagW[0]) bank[bankSel][1:0] <= ALUFlags[1:0];
    end
  end

  // IT FSM next-state logic.
  always_comb begin
    state_nxt   = state;
    remain_nxt  = remain;
    idx_nxt     = idx;
    itcondr_nxt = itcondr;
    itmaskr_nxt = itmaskr;
    if (flush) begin
      state_nxt  = IDLE;
      remain_nxt = '0;
      idx_nxt    = '0;
    end else if (en) begin
      case (state)
        IDLE: begin
          if (go && itStart && (itCount != '0)) begin
            state_nxt   = ACTIVE;
            remain_nxt  = (itCount > ITW'(ITMAX)) ? ITW'(ITMAX) : itCount;
            idx_nxt     = '0;
            itcondr_nxt = itCond;
            itmaskr_nxt = itMask;
          end
        end
        ACTIVE: begin
          remain_nxt = remain - ITW'(1);
          if (remain == ITW'(1)) begin
            state_nxt = IDLE;
            idx_nxt   = '0;
          end else begin
            idx_nxt = idx + IDXW'(1);
          end
        end
        default: begin
          state_nxt  = IDLE;
          remain_nxt = '0;
          idx_nxt    = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      remain  <= '0;
      idx     <= '0;
      itcondr <= '0;
      itmaskr <= '0;
    end else begin
      state   <= state_nxt;
      remain  <= remain_nxt;
      idx     <= idx_nxt;
      itcondr <= itcondr_nxt;
      itmaskr <= itmaskr_nxt;
    end
  end

endmodule

// File: tb/tb_condlogic_pipe.sv
module tb_condlogic_pipe;

  localparam int NBANK = 2;
  localparam int BW    = 1;
  localparam int ITMAX = 4;
  localparam int ITW   = 3;

  logic             clk = 1'b0;
  logic             reset;
  logic             en;
  logic             flush;
  logic [3:0]       cond;
  logic [BW-1:0]    bankSel;
  logic [3:0]       ALUFlags;
  logic [1:0]       flagW;
  logic             PCS;
  logic             regW;
  logic             memW;
  logic             itStart;
  logic [ITW-1:0]   itCount;
  logic [3:0]       itCond;
  logic [ITMAX-1:0] itMask;
  logic             condEx;
  logic             PCSrc;
  logic             regWrite;
  logic             memWrite;
  logic             itActive;
  logic [3:0]       flagsOut;

  int nchecks = 0;
  int nerrors = 0;

  condlogic_pipe #(.NBANK(NBANK), .BW(BW), .ITMAX(ITMAX), .ITW(ITW)) dut (
    .clk(clk), .reset(reset), .en(en), .flush(flush), .cond(cond),
    .bankSel(bankSel), .ALUFlags(ALUFlags), .flagW(flagW), .PCS(PCS),
    .regW(regW), .memW(memW), .itStart(itStart), .itCount(itCount),
    .itCond(itCond), .itMask(itMask), .condEx(condEx), .PCSrc(PCSrc),
    .regWrite(regWrite), .memWrite(memWrite), .itActive(itActive),
    .flagsOut(flagsOut)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    nchecks++;
    if (got !== exp) begin
      nerrors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to the next falling edge and return all inputs to an idle default.
  task automatic step();
    @(negedge clk);
    reset    = 1'b0;
    en       = 1'b0;
    flush    = 1'b0;
    cond     = 4'hE;
    bankSel  = '0;
    ALUFlags = '0;
    flagW    = '0;
    PCS      = 1'b0;
    regW     = 1'b0;
    memW     = 1'b0;
    itStart  = 1'b0;
    itCount  = '0;
    itCond   = '0;
    itMask   = '0;
  endtask

  task automatic start_it(input logic [ITW-1:0] cnt, input logic [3:0] c, input logic [ITMAX-1:0] m);
    step();
    en = 1'b1; itStart = 1'b1; itCount = cnt; itCond = c; itMask = m;
    #1;
    check("it_start_idle", itActive, 0);
  endtask

  // One accepted block member with the given own cond and regW=1.
  task automatic member(input string tag, input logic [3:0] own, input logic act, input logic rw);
    step();
    en = 1'b1; cond = own; regW = 1'b1;
    #1;
    check({tag, "_act"}, itActive, act);
    check({tag, "_rw"}, regWrite, rw);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; en = 1'b0; flush = 1'b0; cond = 4'hE; bankSel = '0;
    ALUFlags = '0; flagW = '0; PCS = 1'b0; regW = 1'b0; memW = 1'b0;
    itStart = 1'b0; itCount = '0; itCond = '0; itMask = '0;

    // Reset forces gated outputs low.
    step();
    reset = 1'b1; en = 1'b1; cond = 4'hE; regW = 1'b1; memW = 1'b1; PCS = 1'b1;
    #1;
    check("rst_regwrite", regWrite, 0);
    check("rst_memwrite", memWrite, 0);
    check("rst_pcsrc", PCSrc, 0);
    check("rst_itactive", itActive, 0);
    check("rst_flags", flagsOut, 4'h0);

    // EQ fails with Z=0.
    step();
    en = 1'b1; cond = 4'h0; regW = 1'b1;
    #1;
    check("eq_z0_condex", condEx, 0);
    check("eq_z0_rw", regWrite, 0);

    // Set Z in bank 0; no same-cycle bypass.
    step();
    en = 1'b1; flagW = 2'b10; ALUFlags = 4'b0100;
    #1;
    check("wr_z_condex", condEx, 1);
    check("wr_z_nobypass", flagsOut, 4'h0);

    step();
    en = 1'b1; cond = 4'h0; regW = 1'b1; memW = 1'b1;
    #1;
    check("eq_z1_rw", regWrite, 1);
    check("eq_z1_mw", memWrite, 1);
    check("bank0_flags", flagsOut, 4'b0100);

    // Bank isolation.
    step();
    en = 1'b1; bankSel = 1'b1; flagW = 2'b11; ALUFlags = 4'hF;
    #1;
    check("bank1_before", flagsOut, 4'h0);

    step();
    cond = 4'h4;
    #1;
    check("bank0_isolated", flagsOut, 4'b0100);
    check("mi_bank0", condEx, 0);
    bankSel = 1'b1;
    #1;
    check("mi_bank1", condEx, 1);
    check("bank1_flags", flagsOut, 4'hF);

    // Partial write on a cleared bank.
    step();
    en = 1'b1; bankSel = 1'b1; flagW = 2'b11; ALUFlags = 4'h0;
    step();
    en = 1'b1; bankSel = 1'b1; flagW = 2'b01; ALUFlags = 4'hF;
    #1;
    check("bank1_cleared", flagsOut, 4'h0);
    step();
    bankSel = 1'b1;
    #1;
    check("partial_flags", flagsOut, 4'b0011);
    cond = 4'h2;
    #1;
    check("cs_pass", condEx, 1);
    cond = 4'h8;
    #1;
    check("hi_pass", condEx, 1);
    cond = 4'hA;
    #1;
    check("ge_fail", condEx, 0);
    cond = 4'hB;
    #1;
    check("lt_pass", condEx, 1);

    // Never condition.
    step();
    en = 1'b1; cond = 4'hF; regW = 1'b1; memW = 1'b1; PCS = 1'b1;
    #1;
    check("nv_condex", condEx, 0);
    check("nv_rw", regWrite, 0);
    check("nv_mw", memWrite, 0);
    check("nv_pc", PCSrc, 0);

    // IT block: bank 0 Z=1, mask 0101 -> EQ, NE, EQ.
    start_it(3'd3, 4'h0, 4'b0101);
    member("it3_m0", 4'hE, 1, 1);
    member("it3_m1", 4'hE, 1, 0);
    member("it3_m2", 4'hE, 1, 1);
    member("it3_after", 4'hE, 0, 1);

    // Stall mid-block holds the index.
    start_it(3'd4, 4'h0, 4'b0101);
    member("st_m0", 4'hE, 1, 1);
    for (int i = 0; i < 2; i++) begin
      step();
      regW = 1'b1;
      #1;
      check("st_hold_act", itActive, 1);
      check("st_hold_rw", regWrite, 0);
    end
    member("st_m1", 4'hE, 1, 0);
    member("st_m2", 4'hE, 1, 1);
    member("st_m3", 4'hE, 1, 0);
    member("st_after", 4'hE, 0, 1);

    // Flush mid-block with a flag write.
    start_it(3'd3, 4'h0, 4'b0111);
    member("fl_m0", 4'hE, 1, 1);
    step();
    en = 1'b1; flush = 1'b1; regW = 1'b1; flagW = 2'b11; ALUFlags = 4'h0;
    #1;
    check("fl_rw", regWrite, 0);
    member("fl_after", 4'h1, 0, 0);
    check("fl_flags_kept", flagsOut, 4'b0100);

    // Oversized count: exactly ITMAX members; itStart inside the block ignored.
    start_it(3'd7, 4'h0, 4'b1111);
    member("big_m0", 4'h1, 1, 1);
    step();
    en = 1'b1; cond = 4'h1; regW = 1'b1; itStart = 1'b1; itCount = 3'd1; itCond = 4'h1;
    #1;
    check("big_m1_rw", regWrite, 1);
    member("big_m2", 4'h1, 1, 1);
    member("big_m3", 4'h1, 1, 1);
    member("big_after", 4'h1, 0, 0);

    // Zero count does not enter the block.
    start_it(3'd0, 4'h0, 4'b1111);
    member("zero_after", 4'h1, 0, 0);

    // Flush together with itStart: no entry.
    step();
    en = 1'b1; flush = 1'b1; itStart = 1'b1; itCount = 3'd2; itCond = 4'h0; itMask = 4'b1111;
    member("flit_after", 4'h1, 0, 0);

    // Reset mid-block aborts it and clears flags.
    start_it(3'd4, 4'h0, 4'b1111);
    member("rs_m0", 4'h0, 1, 1);
    step();
    reset = 1'b1; en = 1'b1; regW = 1'b1;
    #1;
    check("rs_act", itActive, 0);
    check("rs_rw", regWrite, 0);
    member("rs_after", 4'h0, 0, 0);
    check("rs_flags", flagsOut, 4'h0);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule
